// File: rtl/axi_bram_pkg.sv
// Shared types and lane-swap helpers for the AXI4-Lite to BRAM port-B bridge.
package axi_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam int unsigned BRAM_RD_LATENCY = 1;

  // BRAM side numbers bits MSB-first: lane j of the BRAM is AXI strobe 3-j.
  function automatic logic [0:3] strb_to_wen(input logic [3:0] strb);
    logic [0:3] wen;
    for (int unsigned j = 0; j < 4; j++) wen[j] = strb[3-j];
    return wen;
  endfunction

  function automatic logic [0:31] le_to_be32(input logic [31:0] d);
    logic [0:31] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  function automatic logic [31:0] be_to_le32(input logic [0:31] d);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[31-i] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_bram_port_ctrl.sv
// AXI4-Lite slave driving BRAM port B: single-beat 32-bit reads/writes,
// round-robin read/write arbitration, fully registered outputs.
module axi_lite_bram_port_ctrl
  import axi_bram_pkg::*;
#(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEMSIZE          = 'h4000,
  parameter int unsigned C_BASEADDR         = 'h00000000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            BRAM_Rst,
  output logic                            BRAM_Clk,
  output logic                            BRAM_EN,
  output logic [0:3]                      BRAM_WEN,
  output logic [0:C_S_AXI_ADDR_WIDTH-1]   BRAM_Addr,
  output logic [0:C_S_AXI_DATA_WIDTH-1]   BRAM_Dout,
  input  logic [0:C_S_AXI_DATA_WIDTH-1]   BRAM_Din
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi_lite_bram_port_ctrl: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (C_MEMSIZE < 'h800 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0) begin : g_bad_memsize
    $error("axi_lite_bram_port_ctrl: C_MEMSIZE must be a power of two >= 'h800");
  end
  if ((C_BASEADDR & (C_MEMSIZE - 1)) != 0) begin : g_bad_base
    $error("axi_lite_bram_port_ctrl: C_BASEADDR must be C_MEMSIZE aligned");
  end
  if (BRAM_RD_LATENCY != 1) begin : g_bad_latency
    $error("axi_lite_bram_port_ctrl: read path assumes a 1-cycle BRAM");
  end

  localparam logic [AW-1:0] BASE        = AW'(C_BASEADDR);
  localparam logic [AW-1:0] OFFSET_MASK = AW'(C_MEMSIZE - 1) & ~AW'(32'd3);

  // Window-relative, word-aligned; out-of-window addresses alias into the BRAM.
  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
    return (a - BASE) & OFFSET_MASK;
  endfunction

  state_t        state_q, state_d;
  logic          last_rd_q, last_rd_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          arready_q, arready_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic          en_q, en_d;
  logic [0:3]    wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [0:31]   dout_q, dout_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wr_pend, rd_pend, grant_wr, grant_rd;

  // Outputs are computed one state ahead so they are registered with the state.
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    arready_d = 1'b0;
    bvalid_d  = 1'b0;
    rvalid_d  = 1'b0;
    en_d      = 1'b0;
    wen_d     = '0;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    wr_pend   = S_AXI_AWVALID & S_AXI_WVALID;
    rd_pend   = S_AXI_ARVALID;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_wr = wr_pend && (!rd_pend || last_rd_q);
        grant_rd = rd_pend && !grant_wr;
        if (grant_wr) begin
          state_d   = ST_WR;
          last_rd_d = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          en_d      = 1'b1;
          wen_d     = strb_to_wen(S_AXI_WSTRB);
          addr_d    = map_addr(S_AXI_AWADDR);
          dout_d    = le_to_be32(S_AXI_WDATA);
        end else if (grant_rd) begin
          state_d   = ST_RD_ADDR;
          last_rd_d = 1'b1;
          arready_d = 1'b1;
          en_d      = 1'b1;
          addr_d    = map_addr(S_AXI_ARADDR);
        end
      end
      ST_WR: begin
        state_d  = ST_WR_RESP;
        bvalid_d = 1'b1;
      end
      ST_WR_RESP: begin
        if (S_AXI_BREADY) state_d = ST_IDLE;
        else              bvalid_d = 1'b1;
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        state_d  = ST_RD_DATA;
        rvalid_d = 1'b1;
        rdata_d  = be_to_le32(BRAM_Din);
      end
      ST_RD_DATA: begin
        if (S_AXI_RREADY) state_d = ST_IDLE;
        else              rvalid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      last_rd_q <= 1'b1;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      en_q      <= 1'b0;
      wen_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      en_q      <= en_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign BRAM_Rst      = ~S_AXI_ARESETN;
  assign BRAM_Clk      = S_AXI_ACLK;
  assign BRAM_EN       = en_q;
  assign BRAM_WEN      = wen_q;
  assign BRAM_Addr     = addr_q;
  assign BRAM_Dout     = dout_q;

endmodule

// File: tb/tb_axi_lite_bram_port_ctrl.sv
// Directed plus randomized bench for axi_lite_bram_port_ctrl with a word-array
// reference memory and a behavioural 1-cycle BRAM attached to port B.
module tb_axi_lite_bram_port_ctrl;

  localparam int unsigned TB_MEMSIZE = 'h4000;
  localparam int unsigned TB_BASE    = 'h8000_0000;
  localparam int unsigned MEMWORDS   = TB_MEMSIZE / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        bram_rst, bram_clk, bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr, bram_dout;
  logic [0:31] bram_din = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] bram_mem [MEMWORDS] = '{default: '0};
  logic [31:0] ref_mem  [MEMWORDS];

  always #5 clk = ~clk;

  axi_lite_bram_port_ctrl #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .C_MEMSIZE(TB_MEMSIZE),
    .C_BASEADDR(TB_BASE)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .BRAM_Rst(bram_rst), .BRAM_Clk(bram_clk), .BRAM_EN(bram_en), .BRAM_WEN(bram_wen),
    .BRAM_Addr(bram_addr), .BRAM_Dout(bram_dout), .BRAM_Din(bram_din)
  );

  // Read-first BRAM; byte k of the numeric word is written when WEN numeric bit k is set.
  always @(posedge bram_clk) begin
    if (bram_en) begin
      int unsigned idx;
      logic [31:0] d;
      logic [3:0]  w;
      idx = (32'(bram_addr) % TB_MEMSIZE) / 4;
      d = bram_dout;
      w = bram_wen;
      bram_din <= bram_mem[idx];
      for (int k = 0; k < 4; k++)
        if (w[k]) bram_mem[idx][8*k +: 8] <= d[8*k +: 8];
    end
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - TB_BASE;
    return (off % TB_MEMSIZE) & ~32'h3;
  endfunction

  function automatic logic [31:0] exp_wen(input logic [3:0] s);
    logic [0:3] w;
    for (int j = 0; j < 4; j++) w[j] = s[3-j];
    return 32'(w);
  endfunction

  function automatic logic [31:0] exp_dout(input logic [31:0] d);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return 32'(r);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned idx;
    idx = exp_addr(a) / 4;
    for (int k = 0; k < 4; k++)
      if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int bdelay);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("wr_awready", 32'(awready), 32'd1);
    check("wr_wready", 32'(wready), 32'd1);
    check("wr_arready", 32'(arready), 32'd0);
    check("wr_en", 32'(bram_en), 32'd1);
    check("wr_wen", 32'(bram_wen), exp_wen(s));
    check("wr_addr", 32'(bram_addr), exp_addr(a));
    check("wr_dout", 32'(bram_dout), exp_dout(d));
    check("wr_bvalid_early", 32'(bvalid), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    ref_write(a, d, s);
    tick();
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
    check("wr_resp_en", 32'(bram_en), 32'd0);
    check("wr_resp_awready", 32'(awready), 32'd0);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check("wr_bvalid_hold", 32'(bvalid), 32'd1);
      check("wr_hold_en", 32'(bram_en), 32'd0);
    end
    bready = 1'b1;
    tick();
    check("wr_bvalid_done", 32'(bvalid), 32'd0);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay);
    logic [31:0] exp;
    exp = ref_mem[exp_addr(a) / 4];
    araddr = a; arvalid = 1'b1;
    tick();
    check("rd_arready", 32'(arready), 32'd1);
    check("rd_awready", 32'(awready), 32'd0);
    check("rd_en", 32'(bram_en), 32'd1);
    check("rd_wen", 32'(bram_wen), 32'd0);
    check("rd_addr", 32'(bram_addr), exp_addr(a));
    arvalid = 1'b0;
    tick();
    check("rd_wait_rvalid", 32'(rvalid), 32'd0);
    check("rd_wait_en", 32'(bram_en), 32'd0);
    check("rd_wait_arready", 32'(arready), 32'd0);
    tick();
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rdata", rdata, exp);
    check("rd_rresp", 32'(rresp), 32'd0);
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check("rd_rvalid_hold", 32'(rvalid), 32'd1);
      check("rd_rdata_hold", rdata, exp);
      check("rd_hold_en", 32'(bram_en), 32'd0);
    end
    rready = 1'b1;
    tick();
    check("rd_rvalid_done", 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;

    for (int i = 0; i < int'(MEMWORDS); i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_en", 32'(bram_en), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bram_rst", 32'(bram_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("run_bram_rst", 32'(bram_rst), 32'd0);

    do_write(TB_BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(TB_BASE + 32'h10, 0);
    check("readback_deadbeef", ref_mem[4], 32'hDEADBEEF);

    do_write(TB_BASE + 32'h20, 32'h11223344, 4'hF, 1);
    do_write(TB_BASE + 32'h20, 32'h000000AA, 4'b0001, 0);
    do_read(TB_BASE + 32'h20, 0);

    do_read(TB_BASE + 32'h10, 5);

    do_read(TB_BASE + TB_MEMSIZE + 32'h4, 0);
    do_write(32'h13, 32'h0BADF00D, 4'hF, 0);
    do_read(TB_BASE + 32'h10, 0);
    do_write(TB_BASE + 32'h30, 32'h12345678, 4'h0, 0);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 1) == 1) ? $urandom : TB_BASE + ($urandom % TB_MEMSIZE);
      if ($urandom_range(0, 3) != 0) a = TB_BASE + ($urandom % 64) * 4;
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d, s, $urandom_range(0, 3));
      else                           do_read(a, $urandom_range(0, 3));
    end

    // Reset while a read sits in the BRAM-wait cycle: nothing may surface afterwards.
    araddr = TB_BASE + 32'h20; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    check("mid_rst_en", 32'(bram_en), 32'd0);
    check("mid_rst_wen", 32'(bram_wen), 32'd0);
    check("mid_rst_addr", 32'(bram_addr), 32'd0);
    check("mid_rst_dout", 32'(bram_dout), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_bram_rst", 32'(bram_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      check("post_rst_en", 32'(bram_en), 32'd0);
    end

    // Simultaneous requests after reset: write first, then read, then the re-queued write.
    awaddr = TB_BASE + 32'h40; wdata = 32'hCAFE0001; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = TB_BASE + 32'h40; arvalid = 1'b1;
    tick();
    check("arb1_awready", 32'(awready), 32'd1);
    check("arb1_arready", 32'(arready), 32'd0);
    check("arb1_addr", 32'(bram_addr), 32'h40);
    ref_write(TB_BASE + 32'h40, 32'hCAFE0001, 4'hF);
    awaddr = TB_BASE + 32'h44; wdata = 32'h5A5A0002;
    bready = 1'b1;
    tick();
    check("arb1_bvalid", 32'(bvalid), 32'd1);
    check("arb1_resp_arready", 32'(arready), 32'd0);
    check("arb1_resp_awready", 32'(awready), 32'd0);
    tick();
    bready = 1'b0;
    check("arb_idle_bvalid", 32'(bvalid), 32'd0);
    check("arb_idle_arready", 32'(arready), 32'd0);
    check("arb_idle_awready", 32'(awready), 32'd0);
    tick();
    check("arb2_arready", 32'(arready), 32'd1);
    check("arb2_awready", 32'(awready), 32'd0);
    check("arb2_addr", 32'(bram_addr), 32'h40);
    arvalid = 1'b0;
    tick();
    check("arb2_wait_awready", 32'(awready), 32'd0);
    tick();
    check("arb2_rvalid", 32'(rvalid), 32'd1);
    check("arb2_rdata", rdata, 32'hCAFE0001);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("arb2_rvalid_done", 32'(rvalid), 32'd0);
    tick();
    check("arb3_awready", 32'(awready), 32'd1);
    check("arb3_addr", 32'(bram_addr), 32'h44);
    ref_write(TB_BASE + 32'h44, 32'h5A5A0002, 4'hF);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    tick();
    check("arb3_bvalid", 32'(bvalid), 32'd1);
    tick();
    bready = 1'b0;
    check("arb3_bvalid_done", 32'(bvalid), 32'd0);
    do_read(TB_BASE + 32'h44, 0);
    do_read(TB_BASE + 32'h40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_bram_port_ctrl.md
Name: axi_lite_bram_port_ctrl

Overview:
AXI4-Lite slave that converts single-beat AXI4-Lite reads and writes into native BRAM port cycles. It drives port B of the MicroBlaze local BRAM block, sitting directly upstream of that block, so the host and debug paths can read and patch instruction/data memory. It is a single-clock FSM with a registered read-data hold and fixed 1-cycle BRAM read latency. Accesses are 32-bit only, with byte-lane strobes.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI address width; also the BRAM_Addr width.
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is legal, other values are an elaboration error.
C_MEMSIZE, 'h4000, BRAM size in bytes; power of two, at least 'h800.
C_BASEADDR, 'h00000000, base address of the window; must be C_MEMSIZE aligned.

Ports:
S_AXI_ACLK  in  1  sole clock; also forwarded to BRAM_Clk.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  32  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  write byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write data handshake.
S_AXI_BRESP  out  2  write response; always 2'b00.
S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write response handshake.
S_AXI_ARADDR  in  32  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read data handshake.
BRAM_Rst  out  1  equals ~S_AXI_ARESETN (combinational).
BRAM_Clk  out  1  equals S_AXI_ACLK.
BRAM_EN  out  1  port enable.
BRAM_WEN  out  [0:3]  byte write enables; bit 0 is the MSB lane.
BRAM_Addr  out  [0:31]  byte address.
BRAM_Dout  out  [0:31]  write data to the BRAM.
BRAM_Din  in  [0:31]  read data from the BRAM.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All *READY, BVALID, RVALID, BRAM_EN and BRAM_WEN are 0.
  - BRAM_Addr, BRAM_Dout and RDATA are 0; last_grant = read.
  - Reset mid-transaction drops the transaction; no response is issued.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_WAIT, RD_DATA. All outputs are registered except BRAM_Rst and BRAM_Clk.
- IDLE arbitration:
  - A write is pending only when AWVALID and WVALID are both 1; one without the other does not start a write.
  - A read is pending when ARVALID is 1.
  - If both are pending, grant the opposite of last_grant (round-robin); otherwise grant whichever is pending.
  - Update last_grant on every grant.
- Write path:
  - IDLE to WR: in WR, AWREADY = WREADY = 1 for exactly one cycle.
  - In the same WR cycle: BRAM_EN = 1, BRAM_WEN[j] = WSTRB[3-j], BRAM_Dout[i] = WDATA[31-i], BRAM_Addr = C_BASEADDR-relative address.
  - WR to WR_RESP: BVALID = 1 and holds until BREADY, then return to IDLE.
  - WSTRB = 0 still performs the BRAM cycle with WEN = 0 and returns BVALID.
- Read path:
  - IDLE to RD_ADDR: ARREADY = 1 and BRAM_EN = 1 for one cycle, WEN = 0.
  - RD_ADDR to RD_WAIT: BRAM output is valid this cycle; capture RDATA[31-i] = BRAM_Din[i].
  - RD_WAIT to RD_DATA: RVALID = 1, RDATA held stable until RREADY, then return to IDLE.
- Latency from VALID sampled in IDLE at cycle 0:
  - Write: READY in cycle 1, BVALID in cycle 2.
  - Read: ARREADY in cycle 1, RVALID in cycle 3.
  - With zero back-pressure, the next transaction can be granted in the cycle after B or R completes.
- Address:
  - BRAM_Addr = ((addr - C_BASEADDR) mod C_MEMSIZE) with bits [1:0] forced to 0.
  - Out-of-window addresses wrap; no error response is generated.
- BRAM_EN and WEN are 0 in every state except WR and RD_ADDR.
- Only one outstanding transaction at a time; no new READY is asserted while BVALID or RVALID is pending.

Decomposition:
- Shared package axi_bram_pkg holds:
  - FSM state enum;
  - RESP_OKAY = 2'b00;
  - BRAM_RD_LATENCY = 1;
  - lane-swap functions strb_to_wen() and le_to_be32().
- No sub-module is needed; the block is a single FSM.

Test Plan:
- Write 0xDEADBEEF to base+0x10 with WSTRB = 4'hF, then read it back: BRAM_WEN = 4'b1111 and BRAM_Addr = 0x10 during WR; RDATA = 0xDEADBEEF and RRESP = 0 at cycle 3.
- Write WSTRB = 4'b0001 with data 0x000000AA over a word holding 0x11223344: WEN = 4'b0001; read back returns 0x112233AA.
- AW+W and AR asserted together in the same cycle, twice in succession: the first grant is the write (last_grant = read after reset), the second is the read, and both complete in order.
- RREADY held low for 5 cycles: RVALID stays 1, RDATA is stable, and no BRAM_EN pulse occurs while waiting.
- Read at base + C_MEMSIZE + 0x4: BRAM_Addr = 0x4 (wraps); write to address 0x13: BRAM_Addr = 0x10.
- ARESETN pulled low while in RD_WAIT: all outputs go to 0 asynchronously; after release, no RVALID is issued and a fresh read completes normally.
